// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative integer divider: operation codes,
// FSM state encoding and small decode helpers.
package div_unit_pkg;

  localparam int DIV_DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    DIV_TYPE_DIV  = 2'd0,
    DIV_TYPE_DIVU = 2'd1,
    DIV_TYPE_REM  = 2'd2,
    DIV_TYPE_REMU = 2'd3
  } div_type_e;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_e;

  // DIV and REM interpret operands as two's complement.
  function automatic logic div_is_signed(input div_type_e t);
    return (t == DIV_TYPE_DIV) || (t == DIV_TYPE_REM);
  endfunction

  // REM and REMU return the remainder, the others the quotient.
  function automatic logic div_is_rem(input div_type_e t);
    return (t == DIV_TYPE_REM) || (t == DIV_TYPE_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// Kept combinational so a wider-radix variant can chain several copies.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;
  logic                ge;
  logic                unused_trial_msb;

  // Shift {rem, quo} left, trial-subtract the divisor, keep the difference
  // when it does not go negative. rem < divisor always holds, so the
  // committed remainder fits back into DATA_WIDTH bits.
  always_comb begin
    shifted          = {rem, quo[DATA_WIDTH-1]};
    trial            = shifted - {1'b0, divisor};
    ge               = (shifted >= {1'b0, divisor});
    unused_trial_msb = trial[DATA_WIDTH];
    rem_next         = ge ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_next         = {quo[DATA_WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV M-extension divider (DIV/DIVU/REM/REMU), one quotient bit
// per clock, with valid/ready request and response ports and flush.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_div_type,
  input  logic [DATA_WIDTH-1:0] i_div_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_div_rs2_data,
  input  logic                  i_div_req_valid,
  output logic                  o_div_req_ready,
  input  logic                  i_div_flush,
  output logic                  o_div_res_valid,
  input  logic                  i_div_res_ready,
  output logic [DATA_WIDTH-1:0] o_div_res,
  output logic                  o_div_busy
);

  localparam int CNT_W = (DATA_WIDTH > 32) ? 7 : 6;
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
    return ~v + DATA_WIDTH'(1);
  endfunction

  div_state_e             state_q;
  div_type_e              type_q;
  logic                   rs1_neg_q;
  logic                   rs2_neg_q;
  logic [DATA_WIDTH-1:0]  divisor_q;
  logic [DATA_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0]  quo_q;
  logic [DATA_WIDTH-1:0]  res_q;
  logic [CNT_W-1:0]       cnt_q;

  div_type_e                     req_type;
  logic                          req_signed;
  logic signed [DATA_WIDTH-1:0]  rs1_s;
  logic signed [DATA_WIDTH-1:0]  rs2_s;
  logic                          rs1_neg;
  logic                          rs2_neg;
  logic [DATA_WIDTH-1:0]         rs1_abs;
  logic [DATA_WIDTH-1:0]         rs2_abs;
  logic                          div_zero;
  logic                          div_ovf;
  logic [DATA_WIDTH-1:0]         step_rem;
  logic [DATA_WIDTH-1:0]         step_quo;
  logic [DATA_WIDTH-1:0]         quo_fix;
  logic [DATA_WIDTH-1:0]         rem_fix;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Request decode: signs, magnitudes and the two cases that skip iteration.
  always_comb begin
    req_type   = div_type_e'(i_div_type);
    req_signed = div_is_signed(req_type);
    rs1_s      = i_div_rs1_data;
    rs2_s      = i_div_rs2_data;
    rs1_neg    = req_signed && (rs1_s < 0);
    rs2_neg    = req_signed && (rs2_s < 0);
    rs1_abs    = rs1_neg ? twos_neg(i_div_rs1_data) : i_div_rs1_data;
    rs2_abs    = rs2_neg ? twos_neg(i_div_rs2_data) : i_div_rs2_data;
    div_zero   = (i_div_rs2_data == '0);
    div_ovf    = req_signed && (i_div_rs1_data == MIN_VAL) && (i_div_rs2_data == '1);
  end

  // Sign fix on the final step: quotient negative when signs differ,
  // remainder follows the dividend. Unsigned types never set the sign flags.
  always_comb begin
    quo_fix = (rs1_neg_q ^ rs2_neg_q) ? twos_neg(step_quo) : step_quo;
    rem_fix = rs1_neg_q ? twos_neg(step_rem) : step_rem;
  end

  // Control FSM with operand latch, iteration counter and result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= DIV_STATE_IDLE;
      type_q    <= DIV_TYPE_DIV;
      rs1_neg_q <= 1'b0;
      rs2_neg_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else if (i_div_flush) begin
      state_q <= DIV_STATE_IDLE;
    end else begin
      case (state_q)
        DIV_STATE_IDLE: begin
          if (i_div_req_valid) begin
            type_q    <= req_type;
            rs1_neg_q <= rs1_neg;
            rs2_neg_q <= rs2_neg;
            divisor_q <= rs2_abs;
            quo_q     <= rs1_abs;
            rem_q     <= '0;
            cnt_q     <= CNT_W'(DATA_WIDTH);
            if (div_zero) begin
              res_q   <= div_is_rem(req_type) ? i_div_rs1_data : '1;
              state_q <= DIV_STATE_DONE;
            end else if (div_ovf) begin
              res_q   <= div_is_rem(req_type) ? '0 : MIN_VAL;
              state_q <= DIV_STATE_DONE;
            end else begin
              state_q <= DIV_STATE_CALC;
            end
          end
        end
        DIV_STATE_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_q   <= div_is_rem(type_q) ? rem_fix : quo_fix;
            state_q <= DIV_STATE_DONE;
          end
        end
        DIV_STATE_DONE: begin
          if (i_div_res_ready) begin
            state_q <= DIV_STATE_IDLE;
          end
        end
        default: state_q <= DIV_STATE_IDLE;
      endcase
    end
  end

  assign o_div_req_ready = (state_q == DIV_STATE_IDLE);
  assign o_div_res_valid = (state_q == DIV_STATE_DONE);
  assign o_div_busy      = (state_q != DIV_STATE_IDLE);
  assign o_div_res       = res_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider for the RV M-extension: DIV, DIVU, REM, REMU.
- Performs the inverse of the core's single-cycle add/shift datapath, using radix-2 restoring division at one quotient bit per clock.
- Sits beside the ALU in the execute stage; the issue logic drives operands through a valid/ready request port and collects the result through a valid/ready response port.
- The request is accepted only when the unit is idle. Execute stalls until the response is taken.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (32); operand/result width; must be 32 or 64.

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_div_type  in  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU
- i_div_rs1_data  in  DATA_WIDTH  dividend
- i_div_rs2_data  in  DATA_WIDTH  divisor
- i_div_req_valid  in  1  request present
- o_div_req_ready  out  1  unit can accept a request (high only in IDLE)
- i_div_flush  in  1  abort current operation (pipeline flush)
- o_div_res_valid  out  1  result available
- i_div_res_ready  in  1  consumer takes result
- o_div_res  out  DATA_WIDTH  quotient or remainder per latched type
- o_div_busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_div_req_ready=1, o_div_res_valid=0, o_div_res=0, o_div_busy=0.
  - All internal registers are cleared.
- States are IDLE, CALC and DONE.
- IDLE:
  - A request is accepted on an edge where i_div_req_valid and o_div_req_ready are both high.
  - On acceptance the unit latches the type, the operand signs, and the absolute values of the operands. Absolute values are taken for signed types only; unsigned types use operands as-is.
  - Remainder register is set to 0, counter to DATA_WIDTH.
  - Divide by zero (rs2==0) goes directly to DONE:
    - quotient = all ones;
    - remainder = rs1 unchanged.
  - Signed overflow (DIV/REM, rs1=MIN, rs2=-1) goes directly to DONE:
    - quotient = MIN;
    - remainder = 0.
  - Every other request goes to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract |divisor| from the rem.
  - If the trial is non-negative, commit it and set quo[0]=1.
  - Decrement the counter. When the counter reaches 1, the next edge moves to DONE.
  - CALC lasts exactly DATA_WIDTH cycles.
- Sign fix is applied when entering DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned types get no fix.
- DONE:
  - o_div_res_valid=1.
  - o_div_res is registered and held stable until the handshake.
  - On an edge with i_div_res_ready=1, the unit returns to IDLE and valid drops.
  - A new request cannot be accepted in the same cycle.
- Latency, counted from the accepting edge to the first cycle with o_div_res_valid=1:
  - normal operation: DATA_WIDTH+1 edges;
  - special cases: 1 edge.
- Throughput is at most one operation per DATA_WIDTH+2 cycles.
- Flush:
  - i_div_flush=1 in any state forces IDLE on the next edge and drops o_div_res_valid; the result is discarded.
  - Flush has priority over both handshakes.
  - A request presented in the same cycle as a flush is not accepted.
- Operand changes after acceptance are ignored.
- i_div_type is only sampled at acceptance.
- DATA_WIDTH=64: use a 7-bit counter; all arithmetic is DATA_WIDTH+1 bits wide for the trial subtract.

Decomposition:
- Add DIV_TYPE_DIV/DIVU/REM/REMU (2-bit) and DIV_STATE_IDLE/CALC/DONE macros to the shared cfg.sv alongside the ALU type codes.
- One combinational sub-module, div_step: inputs {rem, quo, divisor}; outputs next {rem, quo}. It lets a future radix-4 variant instantiate it twice.
- The counter, FSM and sign fix stay in div_unit.

Test Plan:
- DIVU 100/7:
  - Accept, then no result valid for DATA_WIDTH cycles.
  - Result valid at accept+33 edges.
  - o_div_res=14; REMU with the same operands gives 2.
- DIV -7/2 (0xFFFFFFF9, 2):
  - DIV gives 0xFFFFFFFD (-3).
  - REM gives 0xFFFFFFFF (-1).
  - REM 7/-2 gives 1.
- Divide by zero, rs1=0x1234, rs2=0:
  - Valid after 1 edge.
  - DIV/DIVU give 0xFFFFFFFF; REM/REMU give 0x1234.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF:
  - Result 0x80000000 after 1 edge.
  - REM gives 0.
- Backpressure and flush:
  - Hold i_div_res_ready=0 for 5 cycles: result stable and req_ready low.
  - Flush mid-CALC (cycle 10): IDLE next edge, no valid, next request computes correctly.
- Reset mid-CALC:
  - Assert i_rst_n=0 asynchronously between edges: outputs go to reset values immediately, with no clock edge needed.
  - After release, 0xFFFFFFFF DIVU 0x10 gives 0x0FFFFFFF.
